// File: rtl/row_pixel_streamer.sv
// row_pixel_streamer: reads result BRAM row by row and serialises each row's pixels
// onto a valid/ready stream, MSB pixel first, with row and frame markers.
module row_pixel_streamer #(
  parameter int ROWS   = 128,
  parameter int COLS   = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [COLS*PIX_W-1:0] bram_dout,
  output logic [PIX_W-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last_col,
  output logic                  m_last_frame,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int COL_W = COLS > 1 ? $clog2(COLS) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [1:0]            lat_q, lat_d;
  logic [COLS*PIX_W-1:0] sh_q, sh_d;
  logic                  last_col, last_row;
  assign last_col = col_q == COL_W'(COLS - 1);
  assign last_row = row_q == ADDR_W'(ROWS - 1);
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lat_d   = lat_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        row_d   = '0;
      end
      FETCH: begin
        state_d = WAIT;
        lat_d   = '0;
      end
      WAIT: if (lat_q == 2'(RD_LAT - 1)) begin
        state_d = STREAM;
        sh_d    = bram_dout;
        col_d   = '0;
      end else lat_d = lat_q + 2'd1;
      STREAM: if (m_ready) begin
        sh_d  = sh_q << PIX_W;
        col_d = last_col ? col_q : col_q + COL_W'(1);
        if (last_col) begin
          state_d = last_row ? DONE : FETCH;
          row_d   = last_row ? row_q : row_q + ADDR_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      lat_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lat_q   <= lat_d;
      sh_q    <= sh_d;
    end
  end
  // Outputs decode registered state only, so reset clears them without waiting for an edge.
  assign bram_en      = state_q == FETCH;
  assign bram_addr    = bram_en ? row_q : '0;
  assign m_valid      = state_q == STREAM;
  assign m_data       = sh_q[COLS*PIX_W-1 -: PIX_W];
  assign m_last_col   = m_valid && last_col;
  assign m_last_frame = m_last_col && last_row;
  assign busy         = state_q != IDLE;
  assign frame_done   = state_q == DONE;
endmodule
